// File: rtl/sd_clock_sequencer.sv
// sd_clock_sequencer: sequences SD divider run/reload and the card clock gate so the clock never glitches mid-transfer
module sd_clock_sequencer #(
   parameter int STABLE_CYCLES = 16,
   parameter int GATE_HOLD     = 4,
   parameter int CNT_W         = 8
) (
   input  logic       AXI_CLOCK,
   input  logic       AXI_RST,
   input  logic       int_clk_en,
   input  logic       sd_clk_en,
   input  logic [7:0] freq_sel,
   input  logic       freq_wr,
   input  logic       bus_busy,
   input  logic       divider_stable,
   output logic [7:0] div_value,
   output logic       div_run,
   output logic       sd_clk_gate,
   output logic       int_clk_stable,
   output logic       change_pending,
   output logic       change_done
);
   localparam logic [2:0] S_OFF       = 3'd0;
   localparam logic [2:0] S_WARMUP    = 3'd1;
   localparam logic [2:0] S_GATED     = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_DRAIN     = 3'd4;
   localparam logic [2:0] S_HOLD_PRE  = 3'd5;
   localparam logic [2:0] S_RELOAD    = 3'd6;
   localparam logic [2:0] S_HOLD_POST = 3'd7;
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(GATE_HOLD - 1);
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       pend_q, pend_d, div_q, div_d;
   logic             run_q, run_d, gate_q, gate_d, stable_q, stable_d;
   logic             chg_q, chg_d, done_q, done_d, reload_q, reload_d;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      div_d    = div_q;
      run_d    = run_q;
      gate_d   = gate_q;
      stable_d = stable_q;
      chg_d    = chg_q;
      done_d   = 1'b0;
      reload_d = reload_q;
      if (freq_wr) begin
         pend_d = freq_sel;
         chg_d  = (state_q != S_OFF) | chg_q;
      end
      // Clock-enable removal is immediate: software owns any transfer it cuts.
      if (state_q != S_OFF && !int_clk_en) begin
         state_d  = S_OFF;
         gate_d   = 1'b0;
         run_d    = 1'b0;
         stable_d = 1'b0;
         cnt_d    = '0;
         reload_d = 1'b0;
      end else begin
         case (state_q)
            S_OFF: begin
               run_d  = int_clk_en;
               gate_d = 1'b0;
               if (int_clk_en) begin
                  state_d = S_WARMUP;
                  div_d   = pend_d;
                  cnt_d   = '0;
               end
            end
            S_WARMUP: begin
               run_d = 1'b1;
               if (!divider_stable) cnt_d = '0;
               else if (cnt_q == STABLE_LAST) begin
                  state_d  = S_GATED;
                  stable_d = 1'b1;
                  cnt_d    = '0;
               end else cnt_d = cnt_q + 1'b1;
            end
            S_GATED: begin
               gate_d = 1'b0;
               cnt_d  = '0;
               if (!divider_stable) begin
                  state_d  = S_WARMUP;
                  stable_d = 1'b0;
               end else if (reload_q) state_d = S_HOLD_POST;
               else if (sd_clk_en) begin
                  state_d = chg_q ? S_HOLD_PRE : S_RUN;
                  gate_d  = !chg_q;
               end
            end
            S_RUN: begin
               if (!divider_stable) begin
                  state_d  = S_WARMUP;
                  gate_d   = 1'b0;
                  stable_d = 1'b0;
                  cnt_d    = '0;
               end else if (!sd_clk_en || chg_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
               if (!bus_busy) begin
                  state_d = chg_q ? S_HOLD_PRE : S_GATED;
                  gate_d  = 1'b0;
                  cnt_d   = '0;
               end
            end
            S_HOLD_PRE: begin
               state_d = (cnt_q == HOLD_LAST) ? S_RELOAD : S_HOLD_PRE;
               cnt_d   = (cnt_q == HOLD_LAST) ? '0 : cnt_q + 1'b1;
            end
            S_RELOAD: begin
               state_d  = S_WARMUP;
               div_d    = pend_q;
               chg_d    = freq_wr;
               run_d    = 1'b0;
               stable_d = 1'b0;
               reload_d = 1'b1;
               cnt_d    = '0;
            end
            default: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d    = '0;
                  reload_d = 1'b0;
                  state_d  = (sd_clk_en && !chg_q) ? S_RUN : S_GATED;
                  gate_d   = sd_clk_en && !chg_q;
                  done_d   = sd_clk_en && !chg_q;
               end else cnt_d = cnt_q + 1'b1;
            end
         endcase
      end
   end
   always_ff @(posedge AXI_CLOCK) begin
      if (AXI_RST) begin
         state_q  <= S_OFF;
         cnt_q    <= '0;
         pend_q   <= '0;
         div_q    <= '0;
         run_q    <= 1'b0;
         gate_q   <= 1'b0;
         stable_q <= 1'b0;
         chg_q    <= 1'b0;
         done_q   <= 1'b0;
         reload_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         div_q    <= div_d;
         run_q    <= run_d;
         gate_q   <= gate_d;
         stable_q <= stable_d;
         chg_q    <= chg_d;
         done_q   <= done_d;
         reload_q <= reload_d;
      end
   end
   assign div_value      = div_q;
   assign div_run        = run_q;
   assign sd_clk_gate    = gate_q;
   assign int_clk_stable = stable_q;
   assign change_pending = chg_q;
   assign change_done    = done_q;
endmodule

// File: tb/tb_sd_clock_sequencer.sv
// tb_sd_clock_sequencer: randomized scoreboard bench for the SD clock sequencer
module tb_sd_clock_sequencer;
   localparam int STABLE_CYCLES = 16;
   localparam int GATE_HOLD     = 4;
   // A divisor change keeps the card clock off for: pre-hold, reload, re-warm, one gated cycle, post-hold.
   localparam int CHANGE_GAP    = GATE_HOLD + 1 + STABLE_CYCLES + 1 + GATE_HOLD;
   typedef struct {
      logic [7:0] d;
      int         gap;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst, int_clk_en, sd_clk_en, freq_wr, bus_busy, divider_stable;
   logic [7:0] freq_sel, div_value;
   logic       div_run, sd_clk_gate, int_clk_stable, change_pending, change_done;
   int         n_vec = 0;
   int         n_err = 0;
   exp_t       sb[$];
   sd_clock_sequencer #(.STABLE_CYCLES(STABLE_CYCLES), .GATE_HOLD(GATE_HOLD), .CNT_W(8)) dut (
      .AXI_CLOCK(clk), .AXI_RST(rst), .int_clk_en(int_clk_en), .sd_clk_en(sd_clk_en),
      .freq_sel(freq_sel), .freq_wr(freq_wr), .bus_busy(bus_busy), .divider_stable(divider_stable),
      .div_value(div_value), .div_run(div_run), .sd_clk_gate(sd_clk_gate),
      .int_clk_stable(int_clk_stable), .change_pending(change_pending), .change_done(change_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_div_value"}, div_value, 8'h00);
      chk({tag, "_div_run"}, div_run, 0);
      chk({tag, "_gate"}, sd_clk_gate, 0);
      chk({tag, "_stable"}, int_clk_stable, 0);
      chk({tag, "_pending"}, change_pending, 0);
      chk({tag, "_done"}, change_done, 0);
   endtask
   task automatic wait_done(input string nm);
      int n = 0;
      while (!change_done && n < 300) begin
         step();
         n++;
      end
      if (!change_done) chk({nm, "_timeout"}, 1, 0);
      step();
   endtask
   task automatic issue(input logic [7:0] v1, input logic [7:0] v2, input bit dbl, input int busy);
      logic [7:0] old = div_value;
      logic [7:0] fin = dbl ? v2 : v1;
      bus_busy = (busy != 0);
      freq_sel = v1;
      freq_wr  = 1'b1;
      step();
      freq_wr = 1'b0;
      if (dbl) begin
         step();
         freq_sel = v2;
         freq_wr  = 1'b1;
         step();
         freq_wr = 1'b0;
      end
      repeat (busy) step();
      if (busy != 0) begin
         chk("busy_gate_held", sd_clk_gate, 1);
         chk("busy_div_held", div_value, old);
      end
      bus_busy = 1'b0;
      sb.push_back('{fin, CHANGE_GAP});
      wait_done("change");
   endtask
   // Monitor: pairs every change_done with the oldest expected change and watches gate behaviour.
   initial begin
      logic prev_gate = 1'b0, prev_busy = 1'b0;
      logic [7:0] prev_div = 8'h00;
      int low_cnt = 0, last_low = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            if (!sd_clk_gate) low_cnt++;
            else if (!prev_gate) begin
               last_low = low_cnt;
               low_cnt  = 0;
            end
            if (prev_gate && sd_clk_gate) chk("div_steady_while_gated_on", div_value, prev_div);
            if (prev_gate && !sd_clk_gate && int_clk_en) chk("gate_fell_while_busy", prev_busy, 0);
            if (change_done) begin
               if (sb.size() == 0) chk("unexpected_change_done", change_done, 0);
               else begin
                  e = sb.pop_front();
                  chk("done_div_value", div_value, e.d);
                  chk("done_gate", sd_clk_gate, 1);
                  chk("done_pending_clear", change_pending, 0);
                  if (e.gap >= 0) chk("gate_off_cycles", last_low, e.gap);
               end
            end
         end else low_cnt = 0;
         prev_gate = sd_clk_gate;
         prev_div  = div_value;
         prev_busy = bus_busy;
      end
   end
   initial begin
      int n;
      rst = 1'b1; int_clk_en = 1'b0; sd_clk_en = 1'b0; freq_wr = 1'b0;
      bus_busy = 1'b0; divider_stable = 1'b1; freq_sel = 8'h00;
      repeat (3) step();
      chk_reset_outputs("reset");
      rst = 1'b0;
      freq_sel = 8'h04;
      freq_wr  = 1'b1;
      step();
      freq_wr = 1'b0;
      chk("off_write_not_pending", change_pending, 0);
      int_clk_en = 1'b1;
      n = 0;
      while (!int_clk_stable && n < 100) begin
         step();
         n++;
      end
      chk("powerup_warmup_len", n, STABLE_CYCLES + 1);
      chk("powerup_div_value", div_value, 8'h04);
      chk("powerup_div_run", div_run, 1);
      sd_clk_en = 1'b1;
      step();
      chk("powerup_gate_on", sd_clk_gate, 1);
      issue(8'h01, 8'h00, 1'b0, 0);
      issue(8'h04, 8'h00, 1'b0, 50);
      issue(8'h02, 8'h07, 1'b1, 0);
      chk("double_write_final", div_value, 8'h07);
      repeat (12) issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
      freq_sel  = 8'h33;
      freq_wr   = 1'b1;
      sd_clk_en = 1'b0;
      step();
      freq_wr = 1'b0;
      repeat (60) step();
      chk("simul_div_value", div_value, 8'h33);
      chk("simul_gate_off", sd_clk_gate, 0);
      chk("simul_pending", change_pending, 0);
      chk("simul_stable", int_clk_stable, 1);
      sd_clk_en = 1'b1;
      step();
      chk("simul_regate", sd_clk_gate, 1);
      sd_clk_en = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (11) step();
      chk("glitch_pre_stable", int_clk_stable, 0);
      divider_stable = 1'b0;
      step();
      divider_stable = 1'b1;
      n = 0;
      while (!int_clk_stable && n < 100) begin
         step();
         n++;
      end
      chk("glitch_recovery_len", n, STABLE_CYCLES);
      sd_clk_en = 1'b1;
      step();
      chk("glitch_gate_on", sd_clk_gate, 1);
      freq_sel = 8'h5A;
      freq_wr  = 1'b1;
      step();
      freq_wr = 1'b0;
      n = 0;
      while (sd_clk_gate && n < 20) begin
         step();
         n++;
      end
      chk("abort_gate_fell", sd_clk_gate, 0);
      step();
      int_clk_en = 1'b0;
      step();
      chk("abort_gate", sd_clk_gate, 0);
      chk("abort_div_run", div_run, 0);
      chk("abort_stable", int_clk_stable, 0);
      chk("abort_pending_kept", change_pending, 1);
      repeat (3) step();
      int_clk_en = 1'b1;
      sb.push_back('{8'h5A, -1});
      wait_done("abort_resume");
      freq_sel = 8'h99;
      freq_wr  = 1'b1;
      step();
      freq_wr = 1'b0;
      repeat (8) step();
      rst = 1'b1;
      int_clk_en = 1'b0;
      step();
      chk_reset_outputs("midseq_reset");
      rst = 1'b0;
      repeat (40) step();
      chk("post_reset_div", div_value, 8'h00);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
